// File: rtl/eq2_share_arbiter.sv
// rtl/eq2_share_arbiter.sv - round-robin sharing of one external 2-bit equality comparator
// Two requesters hand over (a,b); the winner drives the comparator, waits out settle time, and gets a tagged result.
module eq2_share_arbiter #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk_amisha,
  input  logic             rst_n_amisha,
  input  logic             req0_valid_amisha,
  input  logic [1:0]       req0_a_amisha,
  input  logic [1:0]       req0_b_amisha,
  output logic             req0_ready_amisha,
  input  logic             req1_valid_amisha,
  input  logic [1:0]       req1_a_amisha,
  input  logic [1:0]       req1_b_amisha,
  output logic             req1_ready_amisha,
  output logic [1:0]       cmp_a_amisha,
  output logic [1:0]       cmp_b_amisha,
  input  logic             cmp_aeqb_amisha,
  output logic             rsp_valid_amisha,
  input  logic             rsp_ready_amisha,
  output logic             rsp_id_amisha,
  output logic             rsp_eq_amisha,
  output logic             busy_amisha,
  output logic [CNT_W-1:0] match_cnt_amisha
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_settle_cnt;
  logic             r_prio;
  logic [1:0]       r_cmp_a;
  logic [1:0]       r_cmp_b;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic             r_rsp_eq;
  logic [CNT_W-1:0] r_match_cnt;

  logic             w_any_valid;
  logic             w_gnt_id;
  logic             w_accept;
  logic             w_settle_done;
  logic             w_rsp_take;

  // With both requesters valid the pointer decides; otherwise the lone valid one wins.
  always_comb begin
    w_any_valid   = req0_valid_amisha | req1_valid_amisha;
    w_gnt_id      = (req0_valid_amisha & req1_valid_amisha) ? r_prio : req1_valid_amisha;
    w_accept      = (r_state == IDLE) & w_any_valid;
    w_settle_done = (r_state == SETTLE) & (r_settle_cnt == 4'd1);
    w_rsp_take    = (r_state == RESP) & rsp_ready_amisha;
    w_state_nxt   = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_state_nxt = SETTLE;
      SETTLE:  if (w_settle_done) w_state_nxt = RESP;
      RESP:    if (w_rsp_take)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      r_settle_cnt <= 4'd0;
      r_prio       <= 1'b0;
      r_cmp_a      <= 2'd0;
      r_cmp_b      <= 2'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_eq     <= 1'b0;
      r_match_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cmp_a      <= w_gnt_id ? req1_a_amisha : req0_a_amisha;
            r_cmp_b      <= w_gnt_id ? req1_b_amisha : req0_b_amisha;
            r_rsp_id     <= w_gnt_id;
            r_settle_cnt <= LP_SETTLE;
          end
        end
        SETTLE: begin
          r_settle_cnt <= r_settle_cnt - 4'd1;
          if (w_settle_done) begin
            r_rsp_eq    <= cmp_aeqb_amisha;
            r_rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (w_rsp_take) begin
            r_rsp_valid <= 1'b0;
            r_prio      <= ~r_rsp_id;
            if (r_rsp_eq && (r_match_cnt != {CNT_W{1'b1}})) begin
              r_match_cnt <= r_match_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready_amisha = w_accept & ~w_gnt_id;
  assign req1_ready_amisha = w_accept & w_gnt_id;
  assign cmp_a_amisha      = r_cmp_a;
  assign cmp_b_amisha      = r_cmp_b;
  assign rsp_valid_amisha  = r_rsp_valid;
  assign rsp_id_amisha     = r_rsp_id;
  assign rsp_eq_amisha     = r_rsp_eq;
  assign busy_amisha       = (r_state != IDLE);
  assign match_cnt_amisha  = r_match_cnt;

endmodule
